// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pll_sup_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUNNING   = 3'd3,
        FAILED    = 3'd4
    } state_t;

    // Largest of three timing parameters; sizes the shared cycle counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Generic 2-flop single-bit synchronizer into the clk domain.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; samples every cycle.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_d, s1_q;
    logic s2_d, s2_q;

    // Shift the asynchronous input through two stages.
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // Synchronizer stages, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: pulses PLL reset, waits for stable lock, retries, flags failure.
// Latency: outputs registered from next state; sys_rst falls 3+STABLE_CYCLES cycles after locked rises.
// Backpressure: none. Optional macro PLL_LOCK_GLITCH_FILTER_EN filters short lock dropouts in RUNNING.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 10,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 8,
    parameter int GLITCH_CYCLES = 4
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               locked,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic               fail,
    output logic [CNT_W-1:0]   retry_cnt,
    output logic [CNT_W-1:0]   lock_loss_cnt,
    output logic [STATE_W-1:0] state_o
);

    localparam int CYC_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);
    localparam logic [CYC_W-1:0] RST_LAST    = CYC_W'(RST_CYCLES - 1);
    localparam logic [CYC_W-1:0] TMO_LAST    = CYC_W'(LOCK_TIMEOUT - 1);
    localparam logic [CYC_W-1:0] STABLE_LAST = CYC_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    // Reject parameter sets that would make a timed state zero-length.
    if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 || GLITCH_CYCLES < 1) begin : g_bad_param
        $error("pll_lock_supervisor: timing parameters must be >= 1");
    end

    state_t            state_d, state_q;
    logic [CYC_W-1:0]  cyc_d, cyc_q;
    logic [CNT_W-1:0]  retry_d, retry_q;
    logic [CNT_W-1:0]  loss_d, loss_q;
    logic              pll_rst_d, pll_rst_q;
    logic              sys_rst_d, sys_rst_q;
    logic              ready_d, ready_q;
    logic              fail_d, fail_q;
    logic              locked_s;
    logic              loss_evt;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

`ifdef PLL_LOCK_GLITCH_FILTER_EN
    localparam int GLT_W = $clog2(GLITCH_CYCLES + 1);
    localparam logic [GLT_W-1:0] GLT_LAST = GLT_W'(GLITCH_CYCLES - 1);
    logic [GLT_W-1:0] glt_d, glt_q;

    // A dropout counts only once it has lasted GLITCH_CYCLES consecutive cycles.
    assign loss_evt = !locked_s && (glt_q == GLT_LAST);

    // Consecutive-unlocked counter, only meaningful while RUNNING.
    always_comb begin
        glt_d = '0;
        if (state_q == RUNNING && !locked_s && !loss_evt) begin
            glt_d = glt_q + 1'b1;
        end
    end

    // Glitch filter register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            glt_q <= '0;
        end else begin
            glt_q <= glt_d;
        end
    end
`else
    // Any unlocked cycle while RUNNING is a lock loss.
    assign loss_evt = !locked_s;
`endif

    // State register plus status counters and registered outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= PLL_RESET;
            cyc_q     <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    // Next-state, shared cycle counter and status counter updates.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        unique case (state_q)
            PLL_RESET: begin
                if (cyc_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // Lock wins over a timeout landing in the same cycle.
                if (locked_s) begin
                    state_d = STABILIZE;
                end else if (cyc_q == TMO_LAST) begin
                    if (retry_q == CNT_W'(MAX_RETRIES)) begin
                        state_d = FAILED;
                    end else begin
                        state_d = PLL_RESET;
                        if (retry_q != CNT_MAX) retry_d = retry_q + 1'b1;
                    end
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (cyc_q == STABLE_LAST) begin
                    state_d = RUNNING;
                    retry_d = '0;
                end
            end
            RUNNING: begin
                if (loss_evt) begin
                    state_d = PLL_RESET;
                    if (loss_q != CNT_MAX) loss_d = loss_q + 1'b1;
                end
            end
            FAILED: begin
                state_d = FAILED;
            end
            default: begin
                state_d = PLL_RESET;
            end
        endcase
        // Counter restarts on every state change and idles in untimed states.
        if (state_d != state_q || state_q == RUNNING || state_q == FAILED) begin
            cyc_d = '0;
        end else begin
            cyc_d = cyc_q + 1'b1;
        end
    end

    // Output decode from the next state so outputs line up with state_q.
    always_comb begin
        pll_rst_d = (state_d == PLL_RESET) || (state_d == FAILED);
        sys_rst_d = (state_d != RUNNING);
        ready_d   = (state_d == RUNNING);
        fail_d    = (state_d == FAILED);
    end

    assign pll_rst       = pll_rst_q;
    assign sys_rst       = sys_rst_q;
    assign ready         = ready_q;
    assign fail          = fail_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;
    assign state_o       = state_q;

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Sits directly downstream of the PLL wrapper, in the always-running 50 MHz refclk domain.
- Drives the PLL's rst input and watches its asynchronous locked output.
- Releases a system reset request (sys_rst) only after lock has been stable for a programmable time.
- Retries the PLL on lock timeout or lock loss; declares failure after a bounded number of retries.

Parameters:
- RST_CYCLES, 10, refclk cycles pll_rst is held high per PLL reset pulse (≥1)
- LOCK_TIMEOUT, 50000, refclk cycles allowed in WAIT_LOCK before a retry (1 ms at 50 MHz)
- STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before RUNNING
- MAX_RETRIES, 3, timeouts tolerated; the next timeout enters FAILED
- CNT_W, 8, width of the status counters
- GLITCH_CYCLES, 4, lock-loss filter length (used only with the optional feature)

Ports:
- refclk  in  1  50 MHz reference clock (same net feeding the PLL)
- rst  in  1  synchronous active-high reset
- locked  in  1  PLL lock indicator, asynchronous to refclk
- pll_rst  out  1  reset to the PLL, active-high
- sys_rst  out  1  system reset request, active-high; high unless in RUNNING
- ready  out  1  high only in RUNNING
- fail  out  1  high only in FAILED
- retry_cnt  out  CNT_W  timeouts since the last RUNNING entry, saturating
- lock_loss_cnt  out  CNT_W  lock losses seen in RUNNING since rst, saturating
- state_o  out  3  encoded current state, for debug

Behaviour:
- One clock, refclk. Reset is synchronous and active-high on rst.
- While rst is high:
  - state = PLL_RESET and cycle counter = 0.
  - pll_rst = 1, sys_rst = 1, ready = 0, fail = 0.
  - retry_cnt = 0, lock_loss_cnt = 0, synchronizer flops = 0.
- locked passes through a 2-flop synchronizer to give locked_s (2-cycle latency). Only locked_s is used.
- All outputs are registered and decoded from state. There is a single shared cycle counter, cleared on every state change.
- PLL_RESET:
  - pll_rst = 1.
  - After RST_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK:
  - pll_rst = 0.
  - If locked_s = 1, go to STABILIZE.
  - Else, when the counter reaches LOCK_TIMEOUT-1:
    - if retry_cnt == MAX_RETRIES, go to FAILED;
    - otherwise increment retry_cnt and go to PLL_RESET.
- STABILIZE:
  - If locked_s = 0, go to WAIT_LOCK with a fresh timeout; no retry is counted.
  - When the counter reaches STABLE_CYCLES-1 with locked_s still 1, go to RUNNING.
- RUNNING:
  - sys_rst = 0, ready = 1.
  - retry_cnt is cleared on entry.
  - If locked_s = 0, increment lock_loss_cnt (saturating) and go to PLL_RESET; sys_rst reasserts on the next cycle.
- FAILED:
  - pll_rst = 1, sys_rst = 1, fail = 1.
  - Terminal; the only exit is rst.
- Timing:
  - From a locked rising edge (seen in WAIT_LOCK) to sys_rst low: 2 (sync) + 1 (transition) + STABLE_CYCLES refclk cycles.
  - After rst deasserts, pll_rst stays high for exactly RST_CYCLES cycles.
- Simultaneous events:
  - If locked_s rises in the same cycle the WAIT_LOCK timeout expires, the lock wins and the state goes to STABILIZE.
  - rst takes priority over every transition.
- Saturation: both counters hold at 2^CNT_W-1.

Optional Feature:
- Macro: PLL_LOCK_GLITCH_FILTER_EN.
- Defined:
  - In RUNNING, lock loss is acted on only after locked_s has been 0 for GLITCH_CYCLES consecutive cycles.
  - Shorter dropouts are ignored; they are neither counted nor cause a state change.
  - The filter counter clears whenever locked_s = 1.
- Undefined: a single cycle of locked_s = 0 in RUNNING triggers lock-loss handling.

Decomposition:
- Shared package pll_sup_pkg holds:
  - state enum: PLL_RESET=0, WAIT_LOCK=1, STABILIZE=2, RUNNING=3, FAILED=4;
  - 3-bit state width constant.
- One natural sub-module: sync_2ff (generic 2-flop bit synchronizer). It is reused later for the reset crossing into the outclk domain.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2, GLITCH_CYCLES=3.
1. Normal lock: rst low at cycle 0, locked rises at cycle 10 → pll_rst high cycles 0–3; sys_rst falls and ready rises at cycle 21; retry_cnt=0.
2. Unstable lock: locked high for 5 cycles then low in STABILIZE → back to WAIT_LOCK; sys_rst stays 1; retry_cnt unchanged; a later stable lock still reaches RUNNING.
3. Never locks: locked held 0 → three PLL_RESET pulses of 4 cycles; retry_cnt reaches 2; then FAILED with fail=1, pll_rst=1; stays there until rst.
4. Lock loss in RUNNING: locked drops for 1 cycle → filter off: lock_loss_cnt=1, pll_rst pulses 4 cycles, relock reaches RUNNING again; filter on: no state change, counter stays 0.
5. rst mid-operation: assert rst during STABILIZE and during RUNNING → the next cycle shows PLL_RESET, pll_rst=1, sys_rst=1, both counters 0.
6. Tie: locked_s rises on the exact timeout cycle → state goes to STABILIZE; retry_cnt is not incremented.
